uart_rx_deframer: RTL

Receiver front end of the UART link. It synchronises the serial line `RxD` and detects start bits. It samples each bit at mid-period using the 16× `Rx_sample_ENABLE` tick from the baud controller, checks even parity and the stop bit, then presents `Data`, `Rx_PERROR` and `Rx_FERROR`. These outputs feed directly into `validation_control`, which in turn drives the 7-segment display path.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rx_line_sync.sv | 31 +++
 rtl/uart_rx_deframer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, framing constants and
// the parity-check helper used by the deframer.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_t;

   localparam int OVERSAMPLE  = 16;
   localparam int DATA_BITS   = 8;
   localparam int MID_SAMPLE  = 7;
   localparam int LAST_SAMPLE = 15;

   // 1'b0 selects even parity, 1'b1 odd parity.
   localparam logic PARITY_ODD = 1'b0;

   // Nonzero when the XOR of the payload and the received parity bit does not
   // match the configured parity mode.
   function automatic logic parity_error(input logic payload_xor, input logic parity_bit);
      return payload_xor ^ parity_bit ^ PARITY_ODD;
   endfunction

endpackage

// File: rtl/rx_line_sync.sv
// Two-flop synchroniser for the asynchronous serial line, plus falling-edge
// detect on the synchronised level. Flops reset to the idle-high line level.
module rx_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic RxD,
   output logic rxd_s,
   output logic rxd_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Metastability filter followed by one delayed copy for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= RxD;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rxd_s    = r_sync;
   assign rxd_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start-bit qualification, mid-bit sampling on the 16x
// tick, even-parity and stop-bit checks, and registered result presentation.
module uart_rx_deframer #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Rx_EN,
   input  logic                 Rx_sample_ENABLE,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] Data,
   output logic                 Rx_PERROR,
   output logic                 Rx_FERROR,
   output logic                 Rx_DONE
);
   import uart_pkg::*;

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic w_rxd_s;
   logic w_rxd_fall;

   rx_state_t            r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;

   rx_line_sync u_line_sync (
      .clk      (clk),
      .reset    (reset),
      .RxD      (RxD),
      .rxd_s    (w_rxd_s),
      .rxd_fall (w_rxd_fall)
   );

   // Frame FSM. Results are loaded on the stop-sample tick so they are already
   // valid during the single DONE cycle in which Rx_DONE is high. The counter
   // wraps 15->0 by itself, so each bit period is exactly one full count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_perr    <= 1'b0;
         Data      <= '0;
         Rx_PERROR <= 1'b0;
         Rx_FERROR <= 1'b0;
         Rx_DONE   <= 1'b0;
      end else begin
         Rx_DONE <= 1'b0;
         if (!Rx_EN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  if (w_rxd_fall) begin
                     r_state <= START;
                  end
               end
               START: begin
                  if (Rx_sample_ENABLE) begin
                     if (r_cnt == CNT_MID) begin
                        r_cnt   <= '0;
                        r_state <= w_rxd_s ? IDLE : DATA;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               DATA: begin
                  if (Rx_sample_ENABLE) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (r_cnt == CNT_LAST) begin
                        r_shift[r_bit_idx] <= w_rxd_s;
                        if (r_bit_idx == IDX_LAST) begin
                           r_bit_idx <= '0;
                           r_state   <= PARITY;
                        end else begin
                           r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                     end
                  end
               end
               PARITY: begin
                  if (Rx_sample_ENABLE) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (r_cnt == CNT_LAST) begin
                        r_perr  <= parity_error(^r_shift, w_rxd_s);
                        r_state <= STOP;
                     end
                  end
               end
               STOP: begin
                  if (Rx_sample_ENABLE) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (r_cnt == CNT_LAST) begin
                        Data      <= r_shift;
                        Rx_PERROR <= r_perr;
                        Rx_FERROR <= ~w_rxd_s;
                        Rx_DONE   <= 1'b1;
                        r_state   <= DONE;
                     end
                  end
               end
               DONE: begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
               default: begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
